// File: rtl/rf_dump_reader_if.sv
// rf_dump_reader_if
// Bundles the register file read port (ra/rd) and the valid/ready dump stream
// produced by rf_dump_reader. The master side is the dump engine; the slave
// side is the register file plus the display/UART consumer.
interface rf_dump_reader_if;
    logic [4:0]  ra;          // register file read address
    logic [31:0] rd;          // register file read data, combinational on ra
    logic        dout_valid;  // output beat valid
    logic        dout_ready;  // consumer ready
    logic [31:0] dout_data;   // captured register value
    logic [4:0]  dout_idx;    // register index of the current beat
    logic        dout_last;   // current beat is the last register of the dump

    modport master (
        output ra,
        input  rd,
        output dout_valid,
        input  dout_ready,
        output dout_data,
        output dout_idx,
        output dout_last
    );

    modport slave (
        input  ra,
        output rd,
        input  dout_valid,
        output dout_ready,
        input  dout_data,
        input  dout_idx,
        input  dout_last
    );
endinterface

// File: rtl/rf_dump_reader.sv
// rf_dump_reader
// Debug read-out engine: on start_i it walks the register file read port from
// FIRST_REG to LAST_REG and streams each value out on a valid/ready channel.
// Each register takes one READ cycle (combinational register file access)
// followed by at least one SEND cycle waiting for the consumer.
// rst_n is synchronous and active-high despite its name.
// Optional feature macro: RF_DUMP_CHECKSUM_EN -- when defined, csum_o is a
// running XOR of every accepted beat; otherwise csum_o is tied to zero.
module rf_dump_reader #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    rf_dump_reader_if.master        bus,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [31:0]             csum_o
);

    // Reject impossible register ranges at elaboration.
    if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG > 31) begin : g_bad_range
        $error("rf_dump_reader: need 0 <= FIRST_REG <= LAST_REG <= 31");
    end

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q;
    logic [4:0]  idx_q;
    logic [4:0]  idx_d;
    logic        valid_q;
    logic [31:0] data_q;
    logic [4:0]  dout_idx_q;

    // Next register index; only used when idx_q is below LAST_IDX, so it never wraps.
    assign idx_d = idx_q + 5'd1;

    // Dump sequencer: walks the index range and captures each register value.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst_n) begin
            state_q    <= IDLE;
            idx_q      <= FIRST_IDX;
            valid_q    <= 1'b0;
            data_q     <= 32'h0;
            dout_idx_q <= 5'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        idx_q   <= FIRST_IDX;
                        state_q <= READ;
                    end
                end
                READ: begin
                    data_q     <= bus.rd;
                    dout_idx_q <= idx_q;
                    valid_q    <= 1'b1;
                    state_q    <= SEND;
                end
                SEND: begin
                    if (bus.dout_ready) begin
                        valid_q <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            state_q <= DONE;
                        end else begin
                            idx_q   <= idx_d;
                            state_q <= READ;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef RF_DUMP_CHECKSUM_EN
    logic [31:0] csum_q;
    logic        hs;

    assign hs = valid_q && bus.dout_ready;

    // Running XOR of accepted beats, cleared by an accepted start.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            csum_q <= 32'h0;
        end else if (state_q == IDLE && start_i) begin
            csum_q <= 32'h0;
        end else if (hs) begin
            csum_q <= csum_q ^ data_q;
        end
    end

    assign csum_o = csum_q;
`else
    assign csum_o = 32'h0;
`endif

    // The read address follows idx, which only moves on start or handshake,
    // so outside READ it holds the last index driven.
    assign bus.ra         = idx_q;
    assign bus.dout_valid = valid_q;
    assign bus.dout_data  = data_q;
    assign bus.dout_idx   = dout_idx_q;
    assign bus.dout_last  = valid_q && (dout_idx_q == LAST_IDX);
    assign busy_o         = (state_q != IDLE);
    assign done_o         = (state_q == DONE);

endmodule

// File: tb/tb_rf_dump_reader.sv
// tb_rf_dump_reader
// Drives two instances (full range and a single-register range) from a shared
// register file array and compares every cycle against a cycle-count model of
// the dump: beat k becomes valid two cycles after the previous handshake, the
// dump ends one cycle after the last handshake.
module tb_rf_dump_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic        start_b;
    logic        busy_o, done_o, busy_b, done_b;
    logic [31:0] csum_o, csum_b;
    logic [31:0] regs [32];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rf_dump_reader_if bus_a ();
    rf_dump_reader_if bus_b ();

    assign bus_a.rd = regs[bus_a.ra];
    assign bus_b.rd = regs[bus_b.ra];

    rf_dump_reader dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .bus     (bus_a),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .csum_o  (csum_o)
    );

    rf_dump_reader #(.FIRST_REG(29), .LAST_REG(29)) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_b),
        .bus     (bus_b),
        .busy_o  (busy_b),
        .done_o  (done_b),
        .csum_o  (csum_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] csum_model(input logic [31:0] x);
`ifdef RF_DUMP_CHECKSUM_EN
        return x;
`else
        return 32'h0 & x;
`endif
    endfunction

    // mode: 0 ready high, 1 random ready, 2 stall 3 cycles on idx 5,
    //       3 second start on idx 10, 4 reset while idx 7 is held
    task automatic run_dump(input int mode);
        int          n          = 32;
        int          k          = 0;
        int          next_valid = 2;
        int          done_cyc   = -1;
        int          stalls     = 0;
        int          stall_left = 3;
        bit          restarted  = 1'b0;
        bit          exp_valid;
        bit          rdy;
        logic [31:0] exp_csum   = 32'h0;
        string       t;

        @(negedge clk);
        start_i = 1'b1;
        bus_a.dout_ready = 1'b1;
        for (int c = 1; c < 1000; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            exp_valid = (k < n) && (c >= next_valid);
            t = $sformatf("m%0d c%0d", mode, c);

            check({t, " valid"}, 32'(bus_a.dout_valid), 32'(exp_valid));
            check({t, " busy"}, 32'(busy_o), 32'(done_cyc < 0 || c <= done_cyc));
            check({t, " done"}, 32'(done_o), 32'(c == done_cyc));
            check({t, " csum"}, csum_o, csum_model(exp_csum));
            check({t, " last"}, 32'(bus_a.dout_last), 32'(exp_valid && k == n - 1));
            if (exp_valid) begin
                check({t, " idx"}, 32'(bus_a.dout_idx), 32'(k));
                check({t, " data"}, bus_a.dout_data, regs[k]);
            end

            if (done_cyc >= 0 && c == done_cyc + 1) begin
                check({t, " latency"}, 32'(done_cyc), 32'(2 * n + 1 + stalls));
                return;
            end

            rdy = 1'b1;
            case (mode)
                1: rdy = ($urandom_range(0, 3) != 0);
                2: if (exp_valid && k == 5 && stall_left > 0) begin
                       rdy = 1'b0;
                       stall_left--;
                   end
                3: if (exp_valid && k == 10 && !restarted) begin
                       start_i = 1'b1;
                       restarted = 1'b1;
                   end
                4: if (exp_valid && k == 7) begin
                       rdy = 1'b0;
                       rst_n = 1'b1;
                       @(negedge clk);
                       rst_n = 1'b0;
                       check("rst valid", 32'(bus_a.dout_valid), 32'h0);
                       check("rst busy", 32'(busy_o), 32'h0);
                       check("rst data", bus_a.dout_data, 32'h0);
                       check("rst idx", 32'(bus_a.dout_idx), 32'h0);
                       check("rst ra", 32'(bus_a.ra), 32'h0);
                       check("rst csum", csum_o, 32'h0);
                       for (int j = 0; j < 3; j++) begin
                           check("rst done", 32'(done_o), 32'h0);
                           @(negedge clk);
                       end
                       return;
                   end
                default: rdy = 1'b1;
            endcase
            bus_a.dout_ready = rdy;

            if (exp_valid && rdy) begin
                exp_csum ^= regs[k];
                if (k == n - 1) done_cyc = c + 1;
                else next_valid = c + 2;
                k++;
            end else if (exp_valid) begin
                stalls++;
            end
        end
        check($sformatf("m%0d timeout", mode), 32'h0, 32'h1);
    endtask

    initial begin
        rst_n = 1'b1;
        start_i = 1'b0;
        start_b = 1'b0;
        bus_a.dout_ready = 1'b0;
        bus_b.dout_ready = 1'b1;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[28] = 32'h0000_1800;
        regs[29] = 32'h0000_2ffc;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset valid", 32'(bus_a.dout_valid), 32'h0);
        check("reset busy", 32'(busy_o), 32'h0);
        check("reset done", 32'(done_o), 32'h0);
        check("reset ra", 32'(bus_a.ra), 32'h0);
        check("reset ra b", 32'(bus_b.ra), 32'd29);
        check("reset data", bus_a.dout_data, 32'h0);
        check("reset idx", 32'(bus_a.dout_idx), 32'h0);
        check("reset last", 32'(bus_a.dout_last), 32'h0);
        check("reset csum", csum_o, 32'h0);
        rst_n = 1'b0;

        run_dump(0);
        check("reset-pattern csum", csum_o, csum_model(32'h0000_37fc));
        run_dump(2);
        run_dump(3);
        run_dump(4);
        run_dump(0);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            run_dump(1);
        end
        run_dump(2);

        // Single-register instance.
        regs[29] = 32'h0000_2ffc;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check("b c1 valid", 32'(bus_b.dout_valid), 32'h0);
        check("b c1 busy", 32'(busy_b), 32'h1);
        @(negedge clk);
        check("b c2 valid", 32'(bus_b.dout_valid), 32'h1);
        check("b c2 data", bus_b.dout_data, 32'h0000_2ffc);
        check("b c2 idx", 32'(bus_b.dout_idx), 32'd29);
        check("b c2 last", 32'(bus_b.dout_last), 32'h1);
        check("b c2 done", 32'(done_b), 32'h0);
        @(negedge clk);
        check("b c3 done", 32'(done_b), 32'h1);
        check("b c3 valid", 32'(bus_b.dout_valid), 32'h0);
        check("b c3 csum", csum_b, csum_model(32'h0000_2ffc));
        @(negedge clk);
        check("b c4 done", 32'(done_b), 32'h0);
        check("b c4 busy", 32'(busy_b), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rf_dump_reader.md
# rf_dump_reader

Debug read-out engine for the single-cycle CPU register file. On a start pulse it walks the register file's read port from FIRST_REG to LAST_REG, captures each 32-bit value and presents it on a valid/ready output stream for the board display or UART path. It is a consumer of the register file read interface and runs only while the CPU is halted. The top level muxes `ra_o` onto read port 0 during that time.

## Interface
- FIRST_REG, 0: first register index dumped (0..31).
- LAST_REG, 31: last register index dumped (FIRST_REG..31).
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  reset, synchronous, active-high (asserted = 1 despite the name).
- start_i  input  1  one-cycle request to begin a dump; ignored unless in IDLE.
- ra_o  output  5  register file read address.
- rd_i  input  32  register file read data; combinational response to `ra_o`.
- dout_valid_o  output  1  output beat valid.
- dout_ready_i  input  1  consumer ready.
- dout_data_o  output  32  captured register value.
- dout_idx_o  output  5  register index of the current beat.
- dout_last_o  output  1  current beat is LAST_REG.
- busy_o  output  1  high in any state other than IDLE.
- done_o  output  1  one-cycle pulse when the dump completes.
- csum_o  output  32  dump checksum (see Configuration).

## Operation
- The FSM has four states: IDLE, READ, SEND, DONE.
- IDLE: `busy_o`=0. `start_i`=1 sets idx←FIRST_REG, clears the checksum and moves to READ.
- READ: `ra_o`=idx. At the clock edge: `dout_data_o`←`rd_i`, `dout_idx_o`←idx, `dout_valid_o`←1, then go to SEND.
- SEND: `dout_valid_o`, `dout_data_o` and `dout_idx_o` hold until `dout_ready_i`=1. A handshake is valid & ready sampled at the edge.
  - On handshake with idx≠LAST_REG: idx←idx+1, `dout_valid_o`←0, go to READ.
  - On handshake with idx=LAST_REG: `dout_valid_o`←0, go to DONE.
- DONE: `done_o`=1 for exactly this cycle, then IDLE unconditionally.
- `dout_last_o` is combinational: `dout_valid_o` AND `dout_idx_o`==LAST_REG.
- `ra_o` outside READ holds the last driven idx (FIRST_REG after reset).
- idx is 5 bits and never wraps. LAST_REG=31 terminates without overflow.
- `start_i` while busy is ignored. There is no queuing and the current dump is unaffected.
- `dout_valid_o` never drops without a handshake, and data never changes while valid=1 and ready=0.
- Reset values: state IDLE, idx=FIRST_REG, `ra_o`=FIRST_REG, `dout_valid_o`=0, `dout_data_o`=0, `dout_idx_o`=0, `dout_last_o`=0, `busy_o`=0, `done_o`=0, `csum_o`=0.
- Reset mid-dump: return to IDLE next edge. The partial beat is discarded and `done_o` is not pulsed.
- Parameters outside 0 ≤ FIRST_REG ≤ LAST_REG ≤ 31 are illegal (elaboration-time check).

## Timing
- `start_i` sampled at edge 0, READ during cycle 1, `dout_valid_o`=1 from cycle 2.
- Each register costs 1 READ cycle plus ≥1 SEND cycle. With ready held high, one beat arrives every 2 cycles.
- A full dump with ready held high takes 2·N cycles from start to the final handshake, N = LAST_REG−FIRST_REG+1. `done_o` follows one cycle later.
- `rd_i` must be stable during READ. The register file read is combinational, so there is no extra wait state.
- Backpressure only stretches SEND. Each stalled cycle adds 1 cycle to the total latency.

## Configuration
- Macro: `RF_DUMP_CHECKSUM_EN`.
- Defined: `csum_o` is a running XOR of every handshaken `dout_data_o`. It is cleared to 0 on an accepted start and updated at each handshake. It is valid when `done_o`=1 and holds until the next start or reset.
- Undefined: no checksum register exists and `csum_o` is tied to 32'h0.
- The stream and handshake behaviour are identical in both builds.

## Test plan
- Reset-state dump, full range, ready always high: 32 beats with idx 0..31. Data is 0 except idx 28=0x00001800 and idx 29=0x00002ffc. `dout_last_o` is high only on idx 31. `done_o` fires at cycle 65.
- Same dump with `RF_DUMP_CHECKSUM_EN`: `csum_o`=0x00001800^0x00002ffc=0x000037fc at `done_o`. Without the macro, `csum_o`=0 throughout.
- Backpressure: ready low for 3 cycles on idx 5 → beat 5 holds data and idx stable for 4 cycles, no beat is skipped or duplicated, total latency +3.
- `start_i` pulsed again mid-dump at idx 10 → ignored. The sequence continues 11..31 with a single `done_o` pulse.
- `rst_n`=1 while in SEND at idx 7 → next cycle `dout_valid_o`=0, `busy_o`=0, no `done_o`. A fresh start dumps from idx 0.
- Parameters FIRST_REG=LAST_REG=29 → a single beat, 0x00002ffc with `dout_last_o`=1. `done_o` fires 3 cycles after start.
